// File: rtl/alu_with_memory_if.sv
// Operation bus between the test program (master) and alu_with_memory (slave).
// Request fields are sampled on the clock edge; response fields are registered.
interface alu_with_memory_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              en;
    logic [3:0]        op;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              zero;
    logic              valid_out;

    modport master (
        output en, op, addr_a, addr_b, addr_d, data_in,
        input  result, carry, zero, valid_out
    );

    modport slave (
        input  en, op, addr_a, addr_b, addr_d, data_in,
        output result, carry, zero, valid_out
    );
endinterface

// File: rtl/alu_with_memory.sv
// Single-cycle ALU over a small register memory: each accepted op reads up to two
// words, computes a result and optionally stores it back, all at one clock edge.
module alu_with_memory #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_with_memory_if.slave    inf
);
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_INC   = 4'hB;
    localparam logic [3:0] OP_DEC   = 4'hC;
    localparam logic [3:0] OP_CMP   = 4'hD;

    localparam logic [DATA_W:0] ONE_EXT = (DATA_W+1)'(1);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DATA_W-1:0]            result_q, result_d;
    logic                         carry_q, carry_d;
    logic                         zero_q, zero_d;
    logic                         valid_q;

    logic [DATA_W-1:0] opa, opb;
    logic [DATA_W:0]   ext;
    logic              upd;
    logic              wr_en;

    // Operands come from pre-edge contents, so a same-edge write is never forwarded.
    assign opa = mem_q[inf.addr_a];
    assign opb = mem_q[inf.addr_b];

    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ext      = '0;
        upd      = 1'b1;
        wr_en    = 1'b1;
        unique case (inf.op)
            OP_WRITE: begin
                result_d = inf.data_in;
                carry_d  = 1'b0;
            end
            OP_READ: begin
                result_d = opa;
                carry_d  = 1'b0;
                wr_en    = 1'b0;
            end
            OP_ADD: begin
                ext      = {1'b0, opa} + {1'b0, opb};
                result_d = ext[DATA_W-1:0];
                carry_d  = ext[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                // Borrow out of the extended subtraction equals (A < B).
                ext      = {1'b0, opa} - {1'b0, opb};
                result_d = ext[DATA_W-1:0];
                carry_d  = ext[DATA_W];
                wr_en    = (inf.op == OP_SUB);
            end
            OP_AND: begin
                result_d = opa & opb;
                carry_d  = 1'b0;
            end
            OP_OR: begin
                result_d = opa | opb;
                carry_d  = 1'b0;
            end
            OP_XOR: begin
                result_d = opa ^ opb;
                carry_d  = 1'b0;
            end
            OP_NOT: begin
                result_d = ~opa;
                carry_d  = 1'b0;
            end
            OP_SHL: begin
                result_d = {opa[DATA_W-2:0], 1'b0};
                carry_d  = opa[DATA_W-1];
            end
            OP_SHR: begin
                result_d = {1'b0, opa[DATA_W-1:1]};
                carry_d  = opa[0];
            end
            OP_INC: begin
                ext      = {1'b0, opa} + ONE_EXT;
                result_d = ext[DATA_W-1:0];
                carry_d  = ext[DATA_W];
            end
            OP_DEC: begin
                ext      = {1'b0, opa} - ONE_EXT;
                result_d = ext[DATA_W-1:0];
                carry_d  = ext[DATA_W];
            end
            default: begin
                upd   = 1'b0;
                wr_en = 1'b0;
            end
        endcase
        if (upd) zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else if (inf.en) begin
            valid_q  <= 1'b1;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            if (wr_en) mem_q[inf.addr_d] <= result_d;
        end else begin
            valid_q  <= 1'b0;
        end
    end

    assign inf.result    = result_q;
    assign inf.carry     = carry_q;
    assign inf.zero      = zero_q;
    assign inf.valid_out = valid_q;
endmodule

// File: tb/tb_alu_with_memory.sv
// Directed bench for alu_with_memory: each step drives one op, then checks the
// registered outputs 1ns after the accepting edge against hand-computed values.
module tb_alu_with_memory;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    alu_with_memory_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    alu_with_memory #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .inf (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] r, input logic c,
                           input logic z, input logic v);
        chk({tag, ".result"}, {24'h0, bus.result}, {24'h0, r});
        chk({tag, ".carry"},  {31'h0, bus.carry},  {31'h0, c});
        chk({tag, ".zero"},   {31'h0, bus.zero},   {31'h0, z});
        chk({tag, ".valid"},  {31'h0, bus.valid_out}, {31'h0, v});
    endtask

    task automatic do_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic [7:0] din);
        bus.en      = 1'b1;
        bus.op      = op;
        bus.addr_a  = a;
        bus.addr_b  = b;
        bus.addr_d  = d;
        bus.data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en = 1'b0;
        bus.op = 4'h2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        bus.en      = 1'b0;
        bus.op      = 4'h0;
        bus.addr_a  = '0;
        bus.addr_b  = '0;
        bus.addr_d  = '0;
        bus.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        do_op(4'h2, 4'd9, 4'd0, 4'd0, 8'h00);
        chk_out("read_after_reset", 8'h00, 1'b0, 1'b1, 1'b1);

        // ADD wrapping to zero with carry out
        do_op(4'h1, 4'd0, 4'd0, 4'd2, 8'h3C);
        chk_out("write_3c", 8'h3C, 1'b0, 1'b0, 1'b1);
        do_op(4'h1, 4'd0, 4'd0, 4'd5, 8'hC4);
        do_op(4'h3, 4'd2, 4'd5, 4'd7, 8'h00);
        chk_out("add_wrap", 8'h00, 1'b1, 1'b1, 1'b1);
        do_op(4'h2, 4'd7, 4'd0, 4'd0, 8'h00);
        chk_out("read_add_dest", 8'h00, 1'b0, 1'b1, 1'b1);

        // SUB with borrow, CMP must not write back
        do_op(4'h1, 4'd0, 4'd0, 4'd1, 8'h10);
        do_op(4'h1, 4'd0, 4'd0, 4'd3, 8'h20);
        do_op(4'h4, 4'd1, 4'd3, 4'd4, 8'h00);
        chk_out("sub_borrow", 8'hF0, 1'b1, 1'b0, 1'b1);
        do_op(4'hD, 4'd3, 4'd3, 4'd4, 8'h00);
        chk_out("cmp_equal", 8'h00, 1'b0, 1'b1, 1'b1);
        do_op(4'h2, 4'd4, 4'd0, 4'd0, 8'h00);
        chk_out("cmp_no_write", 8'hF0, 1'b0, 1'b0, 1'b1);

        // Logic and shifts on A=A5, B=0F
        do_op(4'h1, 4'd0, 4'd0, 4'd8, 8'hA5);
        do_op(4'h1, 4'd0, 4'd0, 4'd9, 8'h0F);
        do_op(4'h5, 4'd8, 4'd9, 4'd10, 8'h00);
        chk_out("and", 8'h05, 1'b0, 1'b0, 1'b1);
        do_op(4'h6, 4'd8, 4'd9, 4'd11, 8'h00);
        chk_out("or", 8'hAF, 1'b0, 1'b0, 1'b1);
        do_op(4'h7, 4'd8, 4'd9, 4'd12, 8'h00);
        chk_out("xor", 8'hAA, 1'b0, 1'b0, 1'b1);
        do_op(4'h8, 4'd8, 4'd0, 4'd13, 8'h00);
        chk_out("not", 8'h5A, 1'b0, 1'b0, 1'b1);
        do_op(4'h9, 4'd8, 4'd0, 4'd14, 8'h00);
        chk_out("shl", 8'h4A, 1'b1, 1'b0, 1'b1);
        do_op(4'hA, 4'd8, 4'd0, 4'd15, 8'h00);
        chk_out("shr", 8'h52, 1'b1, 1'b0, 1'b1);
        do_op(4'h2, 4'd10, 4'd0, 4'd0, 8'h00);
        chk_out("read_and_dest", 8'h05, 1'b0, 1'b0, 1'b1);
        do_op(4'h2, 4'd15, 4'd0, 4'd0, 8'h00);
        chk_out("read_shr_dest", 8'h52, 1'b0, 1'b0, 1'b1);

        // Back-to-back dependency and INC/DEC wrap
        do_op(4'h1, 4'd0, 4'd0, 4'd0, 8'h01);
        do_op(4'hB, 4'd0, 4'd0, 4'd0, 8'h00);
        chk_out("inc_b2b", 8'h02, 1'b0, 1'b0, 1'b1);
        do_op(4'hB, 4'd0, 4'd0, 4'd0, 8'h00);
        chk_out("inc_again", 8'h03, 1'b0, 1'b0, 1'b1);
        do_op(4'hC, 4'd6, 4'd0, 4'd6, 8'h00);
        chk_out("dec_wrap", 8'hFF, 1'b1, 1'b0, 1'b1);
        do_op(4'hB, 4'd6, 4'd0, 4'd6, 8'h00);
        chk_out("inc_wrap", 8'h00, 1'b1, 1'b1, 1'b1);

        // NOP and unlisted opcode hold outputs; en=0 drops valid and holds result
        do_op(4'h1, 4'd0, 4'd0, 4'd2, 8'h99);
        do_op(4'h0, 4'd2, 4'd2, 4'd2, 8'h11);
        chk_out("nop_hold", 8'h99, 1'b0, 1'b0, 1'b1);
        do_op(4'hF, 4'd2, 4'd2, 4'd2, 8'h11);
        chk_out("undef_hold", 8'h99, 1'b0, 1'b0, 1'b1);
        idle();
        chk_out("idle_1", 8'h99, 1'b0, 1'b0, 1'b0);
        bus.data_in = 8'h44;
        bus.addr_d  = 4'd2;
        idle();
        chk_out("idle_2", 8'h99, 1'b0, 1'b0, 1'b0);
        do_op(4'h2, 4'd2, 4'd0, 4'd0, 8'h00);
        chk_out("idle_mem_kept", 8'h99, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges with an op pending
        do_op(4'h1, 4'd0, 4'd0, 4'd3, 8'h5A);
        bus.en      = 1'b1;
        bus.op      = 4'h1;
        bus.addr_d  = 4'd3;
        bus.data_in = 8'h77;
        #2;
        rst = 1'b0;
        #1;
        chk_out("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_out("reset_held", 8'h00, 1'b0, 1'b0, 1'b0);
        bus.en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_op(4'h2, 4'd3, 4'd0, 4'd0, 8'h00);
        chk_out("mem3_cleared", 8'h00, 1'b0, 1'b1, 1'b1);
        do_op(4'h2, 4'd8, 4'd0, 4'd0, 8'h00);
        chk_out("mem8_cleared", 8'h00, 1'b0, 1'b1, 1'b1);
        do_op(4'h2, 4'd2, 4'd0, 4'd0, 8'h00);
        chk_out("mem2_cleared", 8'h00, 1'b0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
